pipelined_custom_adder: RTL



---
 rtl/pipelined_custom_adder_pkg.sv | 22 ++
 rtl/pipelined_custom_adder_chunk_stage.sv | 48 ++++
 rtl/pipelined_custom_adder.sv | 95 +++++++++
 3 files changed

// File: rtl/pipelined_custom_adder_pkg.sv
// Shared sizing helpers for the pipelined custom adder: sum width, stage count
// and the bit bounds of each carry-chain slice.
package pca_pkg;

  function automatic int sum_width(input int a_width);
    return a_width + 1;
  endfunction

  function automatic int num_stages(input int w, input int chunk);
    return (w + chunk - 1) / chunk;
  endfunction

  function automatic int slice_lo(input int k, input int chunk);
    return k * chunk;
  endfunction

  // The top slice is clipped to the sum width, so it may be narrower than chunk.
  function automatic int slice_hi(input int k, input int chunk, input int w);
    return ((k + 1) * chunk < w) ? (k + 1) * chunk - 1 : w - 1;
  endfunction

endpackage

// File: rtl/pipelined_custom_adder_chunk_stage.sv
// One registered slice of the carry chain: adds two CW-bit slices plus a carry-in
// and holds the slice sum, carry-out and valid bit until the next enabled edge.
module adder_chunk_stage
  import pca_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          valid_i,
  input  logic          carry_i,
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  output logic          valid_o,
  output logic          carry_o,
  output logic [CW-1:0] sum_o
);

  logic [CW:0]   total;
  logic [CW-1:0] sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          valid_q, valid_d;

  always_comb begin
    total   = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, carry_i};
    sum_d   = total[CW-1:0];
    carry_d = total[CW];
    valid_d = valid_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (en) begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign sum_o   = sum_q;
  assign carry_o = carry_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipelined_custom_adder.sv
// Exact (A_WIDTH+1)-bit adder of a wide and a narrow operand, carry chain split
// into CHUNK-bit slices with one slice per pipeline stage and a global stall.
module pipelined_custom_adder
  import pca_pkg::*;
#(
  parameter int A_WIDTH = 50,
  parameter int B_WIDTH = 39,
  parameter int CHUNK   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_WIDTH:0]   sum
);

  localparam int W      = sum_width(A_WIDTH);
  localparam int STAGES = num_stages(W, CHUNK);

  logic         advance;
  logic [W-1:0] a_ext, b_ext;
  logic [W-1:0] a_fwd_q [STAGES];
  logic [W-1:0] b_fwd_q [STAGES];
  logic [W-1:0] done    [STAGES];
  logic         carry       [STAGES];
  logic         stage_valid [STAGES];

  // Whole pipe moves in lockstep; bubbles are kept rather than collapsed.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign a_ext = {is_signed & a[A_WIDTH-1], a};
  assign b_ext = {{(W - B_WIDTH){is_signed & b[B_WIDTH-1]}}, b};

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = slice_lo(gi, CHUNK);
    localparam int HI = slice_hi(gi, CHUNK, W);
    localparam int CW = HI - LO + 1;

    logic [W-1:0]  a_src, b_src, low_src, low_q;
    logic          carry_src, valid_src;
    logic [CW-1:0] slice_sum;

    if (gi == 0) begin : g_head
      assign a_src     = a_ext;
      assign b_src     = b_ext;
      assign low_src   = '0;
      assign carry_src = 1'b0;
      assign valid_src = in_valid;
    end else begin : g_body
      assign a_src     = a_fwd_q[gi-1];
      assign b_src     = b_fwd_q[gi-1];
      assign low_src   = done[gi-1];
      assign carry_src = carry[gi-1];
      assign valid_src = stage_valid[gi-1];
    end

    adder_chunk_stage #(.CW(CW)) u_slice (
      .clk     (clk),
      .rst     (rst),
      .en      (advance),
      .valid_i (valid_src),
      .carry_i (carry_src),
      .a_i     (a_src[HI:LO]),
      .b_i     (b_src[HI:LO]),
      .valid_o (stage_valid[gi]),
      .carry_o (carry[gi]),
      .sum_o   (slice_sum)
    );

    // Operands ride along for the upper slices; finished lower sum bits are delayed.
    always_ff @(posedge clk) begin
      if (rst) begin
        a_fwd_q[gi] <= '0;
        b_fwd_q[gi] <= '0;
        low_q       <= '0;
      end else if (advance) begin
        a_fwd_q[gi] <= a_src;
        b_fwd_q[gi] <= b_src;
        low_q       <= low_src;
      end
    end

    assign done[gi] = low_q | (W'(slice_sum) << LO);
  end

  assign out_valid = stage_valid[STAGES-1];
  assign sum       = done[STAGES-1];

endmodule
